weight_loader: RTL and testbench
================================

WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, meaning per-bank weight address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning weight byte width.
REQ-003 SHALL have parameter CNT_WIDTH, default 14, meaning layer byte-count width (ADDR_WIDTH+3, for 8 banks).
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  single-cycle load request.
REQ-007 SHALL have port abort  input  1  cancel an in-progress load.
REQ-008 SHALL have port layer_sel  input  4  layer index to load, 1..8.
REQ-009 SHALL have port byte_count  input  CNT_WIDTH  number of weight bytes in the layer.
REQ-010 SHALL have port s_valid  input  1  stream byte valid.
REQ-011 SHALL have port s_data  input  DATA_WIDTH  stream byte.
REQ-012 SHALL have port s_ready  output  1  stream byte accepted when s_valid&&s_ready.
REQ-013 SHALL have port wr_en  output  8  one-hot per-bank write strobe.
REQ-014 SHALL have port cs  output  8  per-bank chip select, equal to wr_en.
REQ-015 SHALL have port wr_addr  output  ADDR_WIDTH  shared bank write address.
REQ-016 SHALL have port wr_data  output  DATA_WIDTH  shared bank write data.
REQ-017 SHALL have port layer2weight_cnt  output  4  latched layer index, driven to all banks.
REQ-018 SHALL have ports busy, done, err  output  1 each  status.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, CHK, DONE.
REQ-020 IDLE: s_ready=0, busy=0; start latches layer_sel into layer2weight_cnt and byte_count, clears the byte index, and moves to LOAD.
REQ-021 start with byte_count==0 SHALL go from IDLE to DONE with no writes.
REQ-022 start while not IDLE SHALL be ignored.
REQ-023 LOAD: s_ready=1, busy=1; byte index i increments per handshake only.
REQ-024 Byte i SHALL be written to bank i[2:0] at address i[ADDR_WIDTH+2:3], round-robin from bank 0.
REQ-025 wr_en, cs, wr_addr, wr_data SHALL be registered, asserted exactly one cycle after the handshake, and zero in all other cycles.
REQ-026 s_valid low in LOAD SHALL stall without writes; throughput SHALL be one byte per cycle.
REQ-027 Handshake of byte byte_count-1 SHALL move to CHK when the checksum feature is compiled in, otherwise to DONE; s_ready SHALL deassert in the next cycle.
REQ-028 DONE SHALL assert done for exactly one cycle, then return to IDLE; busy SHALL be 0 in DONE.
REQ-029 abort in LOAD or CHK SHALL return to IDLE next cycle, with no done pulse and no further writes after that cycle; abort has priority over a simultaneous handshake.
REQ-030 layer2weight_cnt SHALL hold its value until the next accepted start.

Reset
REQ-031 Reset SHALL force IDLE and clear wr_en, cs, wr_addr, wr_data, layer2weight_cnt, index, busy, done, err, and s_ready to 0.
REQ-032 Reset asserted mid-load SHALL take effect immediately, with no write strobe during or after reset.

Configuration
REQ-033 Macro WL_CHECKSUM_EN defined: a 16-bit modulo-2^16 sum of data bytes accumulates; CHK accepts 2 trailing bytes (MSB first), which are not written; on mismatch, err=1 alongside done; err clears on next start.
REQ-034 WL_CHECKSUM_EN undefined: no CHK state, err tied 0, sum logic absent.

Verification
REQ-035 Reset, start layer_sel=3, byte_count=16, bytes 0x00..0x0F continuous: each bank k receives addr0=k and addr1=k+8, done pulses once, layer2weight_cnt=3.
REQ-036 byte_count=5 with s_valid toggling every other cycle: exactly 5 writes, to banks 0..4 at addr 0, no write in stall cycles.
REQ-037 start with byte_count=0: done on the next cycle, wr_en never asserted.
REQ-038 abort after 3 of 10 bytes: 3 writes only, no done, busy=0 the next cycle; a second start is then accepted.
REQ-039 With WL_CHECKSUM_EN, bytes 01 02 03 followed by checksum 00 06 gives done with err=0; checksum 00 07 gives done with err=1.
REQ-040 rst_n low during byte 4 of 8: all outputs go to 0 at once; after release, the FSM is in IDLE.

Source files
------------

// File: rtl/weight_loader.sv
// -----------------------------------------------------------------------------
// weight_loader
//
// Purpose:
//   Streams a layer's weight bytes into eight weight banks, round-robin.
//   Byte i goes to bank i[2:0] at address i[ADDR_WIDTH+2:3]. The loaded layer
//   index is latched on start and driven to all banks.
//
// Optional feature (macro WL_CHECKSUM_EN):
//   When defined, a 16-bit modulo-2^16 sum of the data bytes is accumulated.
//   Two trailing checksum bytes (MSB first) are then accepted and not written.
//   On a mismatch, err is raised alongside done. err clears on the next start.
//   When undefined, there is no CHK state, err is tied low and no sum logic
//   exists.
//
// Ports:
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   start            single-cycle load request (ignored unless idle)
//   abort            cancel an in-progress load
//   layer_sel        layer index to load (1..8)
//   byte_count       number of weight bytes in the layer
//   s_valid/s_data   input byte stream
//   s_ready          stream byte accepted when s_valid && s_ready
//   wr_en            one-hot per-bank write strobe (registered)
//   cs               per-bank chip select, identical to wr_en
//   wr_addr          shared bank write address (registered)
//   wr_data          shared bank write data (registered)
//   layer2weight_cnt latched layer index
//   busy/done/err    status
// -----------------------------------------------------------------------------
module weight_loader #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [3:0]            layer_sel,
  input  logic [CNT_WIDTH-1:0]  byte_count,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic [7:0]            wr_en,
  output logic [7:0]            cs,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [3:0]            layer2weight_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

`ifdef WL_CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CHK  = 2'd2,
    DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd3
  } state_t;
`endif

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    idx_q, idx_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [3:0]              layer_q, layer_d;
  logic [7:0]              wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    hs;
  logic                    last_byte;

`ifdef WL_CHECKSUM_EN
  logic [15:0]             sum_q, sum_d;
  logic [7:0]              chk_hi_q, chk_hi_d;
  logic                    chk_phase_q, chk_phase_d;
  logic                    err_q, err_d;
`endif

  // Status and ready are pure functions of the state register, so reset
  // forces them low together with the state.
`ifdef WL_CHECKSUM_EN
  assign s_ready = (state_q == LOAD) || (state_q == CHK);
  assign err     = err_q;
`else
  assign s_ready = (state_q == LOAD);
  assign err     = 1'b0;
`endif
  assign busy             = s_ready;
  assign done             = (state_q == DONE);
  assign hs               = s_valid && s_ready;
  assign last_byte        = (idx_q == (cnt_q - CNT_WIDTH'(1)));
  assign wr_en            = wr_en_q;
  assign cs               = wr_en_q;
  assign wr_addr          = wr_addr_q;
  assign wr_data          = wr_data_q;
  assign layer2weight_cnt = layer_q;

  // State and datapath registers; the write port registers default to zero
  // every cycle so a strobe lasts exactly one cycle after its handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      layer_q     <= '0;
      wr_en_q     <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
`ifdef WL_CHECKSUM_EN
      sum_q       <= '0;
      chk_hi_q    <= '0;
      chk_phase_q <= 1'b0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      layer_q     <= layer_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
`ifdef WL_CHECKSUM_EN
      sum_q       <= sum_d;
      chk_hi_q    <= chk_hi_d;
      chk_phase_q <= chk_phase_d;
      err_q       <= err_d;
`endif
    end
  end

  // Next-state logic. Abort is checked before the handshake so a byte
  // presented in the abort cycle is dropped.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    layer_d     = layer_q;
    wr_en_d     = '0;
    wr_addr_d   = '0;
    wr_data_d   = '0;
`ifdef WL_CHECKSUM_EN
    sum_d       = sum_q;
    chk_hi_d    = chk_hi_q;
    chk_phase_d = chk_phase_q;
    err_d       = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          layer_d = layer_sel;
          cnt_d   = byte_count;
          idx_d   = '0;
`ifdef WL_CHECKSUM_EN
          sum_d       = '0;
          chk_phase_d = 1'b0;
          err_d       = 1'b0;
`endif
          state_d = (byte_count == '0) ? DONE : LOAD;
        end
      end

      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (hs) begin
          wr_en_d   = 8'(1) << idx_q[2:0];
          wr_addr_d = idx_q[ADDR_WIDTH+2:3];
          wr_data_d = s_data;
          idx_d     = idx_q + CNT_WIDTH'(1);
`ifdef WL_CHECKSUM_EN
          sum_d     = sum_q + 16'(s_data);
          if (last_byte) state_d = CHK;
`else
          if (last_byte) state_d = DONE;
`endif
        end
      end

`ifdef WL_CHECKSUM_EN
      // Two trailing bytes form the expected sum, high byte first.
      CHK: begin
        if (abort) begin
          state_d = IDLE;
        end else if (hs) begin
          if (!chk_phase_q) begin
            chk_hi_d    = s_data[7:0];
            chk_phase_d = 1'b1;
          end else begin
            err_d   = ({chk_hi_q, s_data[7:0]} != sum_q);
            state_d = DONE;
          end
        end
      end
`endif

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_weight_loader.sv
// -----------------------------------------------------------------------------
// tb_weight_loader
//
// Self-checking bench for weight_loader. Expected bank writes are pushed to a
// scoreboard queue as bytes are handshaken and compared by a monitor when the
// DUT strobes wr_en. Define WL_CHECKSUM_EN to also exercise the checksum path.
// -----------------------------------------------------------------------------
module tb_weight_loader;

  localparam int AW = 11;
  localparam int DW = 8;
  localparam int CW = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [3:0]    layer_sel;
  logic [CW-1:0] byte_count;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic [7:0]    wr_en;
  logic [7:0]    cs;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [3:0]    layer2weight_cnt;
  logic          busy;
  logic          done;
  logic          err;

  typedef struct packed {
    logic [7:0]    en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t         expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          writeCount = 0;
  int          doneCount = 0;
  int          tbIdx = 0;
  logic [15:0] modelSum = 16'h0;

  always #5 clk = ~clk;

  weight_loader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .layer_sel       (layer_sel),
    .byte_count      (byte_count),
    .s_valid         (s_valid),
    .s_data          (s_data),
    .s_ready         (s_ready),
    .wr_en           (wr_en),
    .cs              (cs),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .layer2weight_cnt(layer2weight_cnt),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  // Monitor: every strobe must match the oldest expected write; idle cycles
  // must keep the write port at zero.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done === 1'b1) doneCount++;
      checks++;
      if (wr_en !== 8'h00) begin
        writeCount++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_write: got en=%h addr=%h data=%h, expected no write",
                   wr_en, wr_addr, wr_data);
        end else begin
          wr_t expW;
          wr_t gotW;
          expW = expQ.pop_front();
          gotW = {wr_en, wr_addr, wr_data};
          if (gotW !== expW || cs !== wr_en) begin
            errors++;
            $display("[TB] FAIL write: got en=%h cs=%h addr=%h data=%h, expected en=%h cs=%h addr=%h data=%h",
                     wr_en, cs, wr_addr, wr_data, expW.en, expW.en, expW.addr, expW.data);
          end
        end
      end else if (cs !== 8'h00 || wr_addr !== '0 || wr_data !== '0) begin
        errors++;
        $display("[TB] FAIL idle_port: got cs=%h addr=%h data=%h, expected all 0",
                 cs, wr_addr, wr_data);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart(input logic [3:0] layer, input logic [CW-1:0] cnt);
    start      = 1'b1;
    layer_sel  = layer;
    byte_count = cnt;
    tbIdx      = 0;
    modelSum   = 16'h0;
    tick();
    start      = 1'b0;
  endtask

  // Present one byte for one cycle; when isData the handshake produces an
  // expected bank write.
  task automatic sendByte(input logic [7:0] b, input bit isData);
    wr_t w;
    s_valid = 1'b1;
    s_data  = b;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL s_ready: got %b, expected 1 (byte %0d)", s_ready, tbIdx);
    end else if (isData) begin
      w.en   = 8'(1) << tbIdx[2:0];
      w.addr = AW'(tbIdx >> 3);
      w.data = b;
      expQ.push_back(w);
      modelSum = modelSum + 16'(b);
      tbIdx++;
    end
    tick();
    s_valid = 1'b0;
  endtask

  task automatic sendTrailer(input logic [15:0] value);
`ifdef WL_CHECKSUM_EN
    sendByte(value[15:8], 1'b0);
    sendByte(value[7:0], 1'b0);
`else
    if (value == 16'hFFFF) $display("[TB] trailer skipped");
`endif
  endtask

  // Called in the cycle the DONE state is expected.
  task automatic expectDone(input string name, input logic expErr);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0 || err !== expErr) begin
      errors++;
      $display("[TB] FAIL %s_done: got done=%b busy=%b s_ready=%b err=%b, expected 1 0 0 %b",
               name, done, busy, s_ready, err, expErr);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_after_done: got done=%b busy=%b pending=%0d, expected 0 0 0",
               name, done, busy, expQ.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; layer_sel = '0;
    byte_count = '0; s_valid = 1'b0; s_data = '0;
    tick();
    tick();
    checks++;
    if ({wr_en, cs, wr_addr, wr_data, layer2weight_cnt, busy, done, err, s_ready} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: got en=%h cs=%h addr=%h data=%h layer=%h busy=%b done=%b err=%b rdy=%b, expected all 0",
               wr_en, cs, wr_addr, wr_data, layer2weight_cnt, busy, done, err, s_ready);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int w0;
    w0 = writeCount;
    pulseStart(4'd3, CW'(16));
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        start = 1'b1; layer_sel = 4'd9; byte_count = CW'(2);
      end
      sendByte(8'(i), 1'b1);
      start = 1'b0;
    end
    sendTrailer(modelSum);
    expectDone("basic", 1'b0);
    checks++;
    if (layer2weight_cnt !== 4'd3 || writeCount - w0 != 16) begin
      errors++;
      $display("[TB] FAIL basic_layer: got layer=%0d writes=%0d, expected 3 16",
               layer2weight_cnt, writeCount - w0);
    end
  endtask

  task automatic test_stall();
    int w0;
    w0 = writeCount;
    pulseStart(4'd1, CW'(5));
    for (int c = 0; c < 9; c++) begin
      if (c % 2 == 0) sendByte(8'hA0 + 8'(c), 1'b1);
      else tick();
    end
    sendTrailer(modelSum);
    expectDone("stall", 1'b0);
    checks++;
    if (writeCount - w0 != 5) begin
      errors++;
      $display("[TB] FAIL stall_writes: got %0d, expected 5", writeCount - w0);
    end
  endtask

  task automatic test_zero_count();
    int w0;
    w0 = writeCount;
    pulseStart(4'd6, CW'(0));
    expectDone("zero", 1'b0);
    tick();
    checks++;
    if (writeCount != w0 || layer2weight_cnt !== 4'd6) begin
      errors++;
      $display("[TB] FAIL zero_writes: got writes=%0d layer=%0d, expected 0 6",
               writeCount - w0, layer2weight_cnt);
    end
  endtask

  task automatic test_abort();
    int w0;
    int d0;
    w0 = writeCount;
    d0 = doneCount;
    pulseStart(4'd2, CW'(10));
    for (int i = 0; i < 3; i++) sendByte(8'h30 + 8'(i), 1'b1);
    abort = 1'b1; s_valid = 1'b1; s_data = 8'hAA;
    tick();
    abort = 1'b0; s_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_idle: got busy=%b s_ready=%b, expected 0 0", busy, s_ready);
    end
    tick(); tick(); tick();
    checks++;
    if (writeCount - w0 != 3 || doneCount != d0 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL abort_writes: got writes=%0d dones=%0d pending=%0d, expected 3 0 0",
               writeCount - w0, doneCount - d0, expQ.size());
    end
    pulseStart(4'd5, CW'(2));
    sendByte(8'h55, 1'b1);
    sendByte(8'h66, 1'b1);
    sendTrailer(modelSum);
    expectDone("restart", 1'b0);
    checks++;
    if (layer2weight_cnt !== 4'd5) begin
      errors++;
      $display("[TB] FAIL restart_layer: got %0d, expected 5", layer2weight_cnt);
    end
  endtask

  task automatic test_reset_midload();
    pulseStart(4'd7, CW'(8));
    for (int i = 0; i < 3; i++) sendByte(8'h70 + 8'(i), 1'b1);
    tick();
    s_valid = 1'b1; s_data = 8'h73;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wr_en, cs, wr_addr, wr_data, layer2weight_cnt, busy, done, err, s_ready} !== '0) begin
      errors++;
      $display("[TB] FAIL midload_reset: got en=%h layer=%h busy=%b done=%b rdy=%b, expected all 0",
               wr_en, layer2weight_cnt, busy, done, s_ready);
    end
    tick();
    tick();
    checks++;
    if (wr_en !== 8'h00 || cs !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_hold: got en=%h cs=%h, expected 0 0", wr_en, cs);
    end
    s_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b0 || done !== 1'b0 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: got busy=%b rdy=%b done=%b pending=%0d, expected 0 0 0 0",
               busy, s_ready, done, expQ.size());
    end
    pulseStart(4'd4, CW'(3));
    for (int i = 0; i < 3; i++) sendByte(8'hC0 + 8'(i), 1'b1);
    sendTrailer(modelSum);
    expectDone("post_reset", 1'b0);
  endtask

`ifdef WL_CHECKSUM_EN
  task automatic test_checksum();
    pulseStart(4'd1, CW'(3));
    sendByte(8'h01, 1'b1); sendByte(8'h02, 1'b1); sendByte(8'h03, 1'b1);
    sendTrailer(16'h0006);
    expectDone("chk_good", 1'b0);
    pulseStart(4'd1, CW'(3));
    sendByte(8'h01, 1'b1); sendByte(8'h02, 1'b1); sendByte(8'h03, 1'b1);
    sendTrailer(16'h0007);
    expectDone("chk_bad", 1'b1);
    pulseStart(4'd1, CW'(1));
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_clear: got %b, expected 0", err);
    end
    sendByte(8'hFF, 1'b1);
    sendTrailer(modelSum);
    expectDone("chk_wrap", 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_count();
    test_abort();
    test_reset_midload();
`ifdef WL_CHECKSUM_EN
    test_checksum();
`endif
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
